// File: rtl/micro_intctl.sv
// micro_intctl: eight-input priority interrupt controller for the 16-bit micro.
// Edge-latched requests, mask/pend/isr/EOI registers in I/O space, and an
// inta/rd vector handshake on the shared data bus.
module micro_intctl #(
    parameter logic [15:0] BASE_ADDR   = 16'h00F0,
    parameter logic [7:0]  VECTOR_BASE = 8'h20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  irq,
    output logic        intr,
    input  logic        inta,
    input  logic        rd,
    input  logic        wr,
    input  logic        iom,
    input  logic [15:0] address_bus,
    inout  wire  [15:0] data_bus
);

    typedef enum logic [1:0] {IDLE, REQ, ACK} state_t;

    state_t      state;
    logic [7:0]  sync1, sync2, irq_prev;
    logic [7:0]  mask, pend, isr;
    logic [2:0]  win;
    logic        win_spur;

    logic [7:0]  edge_det;
    logic        elig_valid;
    logic [2:0]  elig_idx;
    logic        blocked;
    logic [7:0]  elig_onehot;
    logic        take;

    logic [15:0] offs;
    logic        reg_sel, reg_wr, reg_rd, vec_rd;
    logic [7:0]  isr_eoi;
    logic [7:0]  vec_off;
    logic        drive_en;
    logic [15:0] drive_val;

    assign edge_det    = sync2 & ~irq_prev;
    assign offs        = address_bus - BASE_ADDR;
    assign reg_sel     = iom & ~inta & (offs[15:2] == 14'd0);
    assign reg_wr      = reg_sel & wr;
    assign reg_rd      = reg_sel & rd & ~wr;
    assign vec_rd      = (state == ACK) & inta & rd & ~wr;
    assign take        = (state == REQ) & inta & elig_valid;
    assign elig_onehot = 8'd1 << elig_idx;

    // Pick the lowest unmasked pending index that lies strictly below the lowest in-service bit
    always_comb begin
        elig_valid = 1'b0;
        elig_idx   = 3'd0;
        blocked    = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (isr[i])
                blocked = 1'b1;
            if (!blocked && !elig_valid && pend[i] && !mask[i]) begin
                elig_valid = 1'b1;
                elig_idx   = 3'(i);
            end
        end
    end

    // EOI is applied to isr before any same-cycle acknowledge sets a new bit
    always_comb begin
        isr_eoi = isr;
        if (reg_wr && offs[1:0] == 2'd3) begin
            if (data_bus[7])
                isr_eoi = isr & (isr - 8'd1);
            else
                isr_eoi[data_bus[2:0]] = 1'b0;
        end
    end

    // Synchronizers, edge register, and the mask/pend/isr registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1    <= '0;
            sync2    <= '0;
            irq_prev <= '0;
            mask     <= '1;
            pend     <= '0;
            isr      <= '0;
        end else begin
            sync1    <= irq;
            sync2    <= sync1;
            irq_prev <= sync2;
            pend     <= (pend & ~(take ? elig_onehot : 8'h00)) | edge_det;
            isr      <= isr_eoi | (take ? elig_onehot : 8'h00);
            if (reg_wr && offs[1:0] == 2'd0)
                mask <= data_bus[7:0];
        end
    end

    // Request/acknowledge handshake with registered intr
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            intr     <= 1'b0;
            win      <= '0;
            win_spur <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (elig_valid) begin
                        state <= REQ;
                        intr  <= 1'b1;
                    end
                end
                REQ: begin
                    if (inta) begin
                        win      <= elig_idx;
                        win_spur <= ~elig_valid;
                        state    <= ACK;
                        intr     <= 1'b0;
                    end else if (!elig_valid) begin
                        state <= IDLE;
                        intr  <= 1'b0;
                    end
                end
                ACK: begin
                    if (!inta)
                        state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    intr  <= 1'b0;
                end
            endcase
        end
    end

    // Bus driver: vector during acknowledge, otherwise register reads; never during a write
    always_comb begin
        drive_en  = 1'b0;
        drive_val = '0;
        vec_off   = win_spur ? 8'h0F : {5'd0, win};
        if (vec_rd) begin
            drive_en  = 1'b1;
            drive_val = {8'h00, VECTOR_BASE + vec_off};
        end else if (reg_rd) begin
            case (offs[1:0])
                2'd0: begin drive_en = 1'b1; drive_val = {8'h00, mask}; end
                2'd1: begin drive_en = 1'b1; drive_val = {8'h00, pend}; end
                2'd2: begin drive_en = 1'b1; drive_val = {8'h00, isr};  end
                default: ;
            endcase
        end
    end

    assign data_bus = drive_en ? drive_val : 16'hzzzz;

endmodule

// File: tb/tb_micro_intctl.sv
// Self-checking bench for micro_intctl: vectors are scored through a queue,
// register and intr behaviour checked inline per scenario.
module tb_micro_intctl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  irq = 8'h00;
    logic        inta = 1'b0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic        iom = 1'b0;
    logic [15:0] address_bus = 16'h0000;
    logic        intr;
    wire  [15:0] data_bus;
    logic        tb_oe = 1'b0;
    logic [15:0] tb_val = 16'h0000;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    assign data_bus = tb_oe ? tb_val : 16'hzzzz;

    always #5 clk = ~clk;

    micro_intctl #(.BASE_ADDR(16'h00F0), .VECTOR_BASE(8'h20)) dut (
        .clk(clk), .reset(reset), .irq(irq), .intr(intr), .inta(inta),
        .rd(rd), .wr(wr), .iom(iom), .address_bus(address_bus), .data_bus(data_bus)
    );

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; irq = 8'h00; inta = 1'b0; rd = 1'b0; wr = 1'b0; iom = 1'b0; tb_oe = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic bus_write(input logic [1:0] off, input logic [7:0] d);
        address_bus = 16'h00F0 + {14'd0, off};
        iom = 1'b1; wr = 1'b1; tb_oe = 1'b1; tb_val = {8'h00, d};
        @(negedge clk);
        iom = 1'b0; wr = 1'b0; tb_oe = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] off, output logic [15:0] d);
        address_bus = 16'h00F0 + {14'd0, off};
        iom = 1'b1; rd = 1'b1;
        #1 d = data_bus;
        rd = 1'b0; iom = 1'b0;
    endtask

    task automatic wait_intr(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (intr === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic do_ack(output logic [15:0] v);
        inta = 1'b1;
        @(negedge clk);
        rd = 1'b1;
        #1 v = data_bus;
        rd = 1'b0; inta = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [15:0] r;
        checks++; if (intr !== 1'b0) begin errors++; $display("FAIL reset_intr: got %b expected 0", intr); end
        checks++; if (!(data_bus === 16'hzzzz || data_bus === 16'h0000)) begin errors++; $display("FAIL reset_bus_hiz: got %h expected zzzz", data_bus); end
        bus_read(2'd0, r);
        checks++; if (r !== 16'h00FF) begin errors++; $display("FAIL reset_mask: got %h expected 00ff", r); end
        bus_read(2'd1, r);
        checks++; if (r !== 16'h0000) begin errors++; $display("FAIL reset_pend: got %h expected 0000", r); end
        bus_read(2'd2, r);
        checks++; if (r !== 16'h0000) begin errors++; $display("FAIL reset_isr: got %h expected 0000", r); end
    endtask

    task automatic test_unmask();
        logic [15:0] r, v, e;
        do_reset();
        bus_write(2'd0, 8'hFE);
        irq[0] = 1'b1;
        exp_q.push_back(16'h0020);
        repeat (3) @(negedge clk);
        checks++; if (intr !== 1'b0) begin errors++; $display("FAIL unmask_intr_early: got %b expected 0", intr); end
        bus_read(2'd1, r);
        checks++; if (r !== 16'h0001) begin errors++; $display("FAIL unmask_pend_set: got %h expected 0001", r); end
        @(negedge clk);
        checks++; if (intr !== 1'b1) begin errors++; $display("FAIL unmask_intr_4cyc: got %b expected 1", intr); end
        do_ack(v);
        e = exp_q.pop_front();
        checks++; if (v !== e) begin errors++; $display("FAIL unmask_vector: got %h expected %h", v, e); end
        checks++; if (intr !== 1'b0) begin errors++; $display("FAIL unmask_intr_after: got %b expected 0", intr); end
        bus_read(2'd2, r);
        checks++; if (r !== 16'h0001) begin errors++; $display("FAIL unmask_isr: got %h expected 0001", r); end
        bus_read(2'd1, r);
        checks++; if (r !== 16'h0000) begin errors++; $display("FAIL unmask_pend_clr: got %h expected 0000", r); end
    endtask

    task automatic test_priority();
        logic [15:0] r, v, e;
        bit ok;
        do_reset();
        bus_write(2'd0, 8'h00);
        irq = 8'h24;
        exp_q.push_back(16'h0022);
        wait_intr(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL prio_intr1: got %b expected 1", ok); end
        do_ack(v);
        e = exp_q.pop_front();
        checks++; if (v !== e) begin errors++; $display("FAIL prio_vector1: got %h expected %h", v, e); end
        bus_read(2'd2, r);
        checks++; if (r !== 16'h0004) begin errors++; $display("FAIL prio_isr: got %h expected 0004", r); end
        bus_read(2'd1, r);
        checks++; if (r !== 16'h0020) begin errors++; $display("FAIL prio_pend: got %h expected 0020", r); end
        repeat (5) @(negedge clk);
        checks++; if (intr !== 1'b0) begin errors++; $display("FAIL prio_blocked: got %b expected 0", intr); end
        bus_write(2'd3, 8'h80);
        exp_q.push_back(16'h0025);
        wait_intr(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL prio_intr2: got %b expected 1", ok); end
        do_ack(v);
        e = exp_q.pop_front();
        checks++; if (v !== e) begin errors++; $display("FAIL prio_vector2: got %h expected %h", v, e); end
        bus_read(2'd2, r);
        checks++; if (r !== 16'h0020) begin errors++; $display("FAIL prio_isr2: got %h expected 0020", r); end
        bus_write(2'd3, 8'h05);
        bus_read(2'd2, r);
        checks++; if (r !== 16'h0000) begin errors++; $display("FAIL prio_eoi_specific: got %h expected 0000", r); end
    endtask

    task automatic test_nesting();
        logic [15:0] r, v, e;
        bit ok;
        do_reset();
        bus_write(2'd0, 8'h00);
        irq[4] = 1'b1;
        exp_q.push_back(16'h0024);
        wait_intr(ok);
        do_ack(v);
        e = exp_q.pop_front();
        checks++; if (v !== e) begin errors++; $display("FAIL nest_vector4: got %h expected %h", v, e); end
        irq[1] = 1'b1;
        exp_q.push_back(16'h0021);
        wait_intr(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL nest_intr: got %b expected 1", ok); end
        do_ack(v);
        e = exp_q.pop_front();
        checks++; if (v !== e) begin errors++; $display("FAIL nest_vector1: got %h expected %h", v, e); end
        bus_read(2'd2, r);
        checks++; if (r !== 16'h0012) begin errors++; $display("FAIL nest_isr: got %h expected 0012", r); end
        bus_write(2'd3, 8'h80);
        bus_read(2'd2, r);
        checks++; if (r !== 16'h0010) begin errors++; $display("FAIL nest_eoi_nonspec: got %h expected 0010", r); end
    endtask

    task automatic test_masking();
        logic [15:0] r, v, e;
        bit ok;
        do_reset();
        bus_write(2'd0, 8'h00);
        irq[3] = 1'b1;
        wait_intr(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL mask_intr_on: got %b expected 1", ok); end
        bus_write(2'd0, 8'h08);
        @(negedge clk);
        checks++; if (intr !== 1'b0) begin errors++; $display("FAIL mask_intr_drop: got %b expected 0", intr); end
        bus_read(2'd1, r);
        checks++; if (r !== 16'h0008) begin errors++; $display("FAIL mask_pend_kept: got %h expected 0008", r); end
        bus_write(2'd0, 8'h00);
        exp_q.push_back(16'h0023);
        wait_intr(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL mask_intr_back: got %b expected 1", ok); end
        do_ack(v);
        e = exp_q.pop_front();
        checks++; if (v !== e) begin errors++; $display("FAIL mask_vector: got %h expected %h", v, e); end
    endtask

    task automatic test_spurious();
        logic [15:0] r, v, e;
        bit ok;
        do_reset();
        bus_write(2'd0, 8'h00);
        irq[6] = 1'b1;
        wait_intr(ok);
        bus_write(2'd0, 8'h40);
        exp_q.push_back(16'h002F);
        do_ack(v);
        e = exp_q.pop_front();
        checks++; if (v !== e) begin errors++; $display("FAIL spur_vector: got %h expected %h", v, e); end
        bus_read(2'd2, r);
        checks++; if (r !== 16'h0000) begin errors++; $display("FAIL spur_isr: got %h expected 0000", r); end
        bus_read(2'd1, r);
        checks++; if (r !== 16'h0040) begin errors++; $display("FAIL spur_pend: got %h expected 0040", r); end
        checks++; if (intr !== 1'b0) begin errors++; $display("FAIL spur_intr: got %b expected 0", intr); end
    endtask

    task automatic test_reset_mid_ack();
        logic [15:0] r, v, e;
        bit ok;
        do_reset();
        bus_write(2'd0, 8'hFE);
        irq[0] = 1'b1;
        exp_q.push_back(16'h0020);
        wait_intr(ok);
        inta = 1'b1;
        @(negedge clk);
        rd = 1'b1;
        #1 v = data_bus;
        e = exp_q.pop_front();
        checks++; if (v !== e) begin errors++; $display("FAIL rst_ack_vector: got %h expected %h", v, e); end
        reset = 1'b0;
        #1;
        checks++; if (!(data_bus === 16'hzzzz || data_bus === 16'h0000)) begin errors++; $display("FAIL rst_ack_hiz: got %h expected zzzz", data_bus); end
        checks++; if (intr !== 1'b0) begin errors++; $display("FAIL rst_ack_intr: got %b expected 0", intr); end
        inta = 1'b0; rd = 1'b0; irq = 8'h00;
        bus_read(2'd0, r);
        checks++; if (r !== 16'h00FF) begin errors++; $display("FAIL rst_ack_mask: got %h expected 00ff", r); end
        bus_read(2'd1, r);
        checks++; if (r !== 16'h0000) begin errors++; $display("FAIL rst_ack_pend: got %h expected 0000", r); end
        bus_read(2'd2, r);
        checks++; if (r !== 16'h0000) begin errors++; $display("FAIL rst_ack_isr: got %h expected 0000", r); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        test_reset();
        test_unmask();
        test_priority();
        test_nesting();
        test_masking();
        test_spurious();
        test_reset_mid_ack();
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_empty: got %0d expected 0", exp_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
